// File: rtl/pattern_gen.sv
// pattern_gen -- registered test-pattern generator for the DVI pixel pipeline.
//
// Takes the current pixel position and produces one registered RGB triple per
// clock (one cycle of latency). The requested pattern is held as "pending" and
// only becomes the displayed pattern at a frame start, so a change never tears
// a frame. Also keeps a completed-frame counter and a bouncing box that moves
// once per frame.
//
// Ports:
//   clk_i          pixel clock
//   rst_n_i        asynchronous active-low reset
//   mode_i         requested pattern (0..7)
//   mode_valid_i   mode_i is captured as the pending pattern when high
//   x_i, y_i       current pixel position
//   red_o/green_o/blue_o  registered colour for the position of the previous cycle
//   mode_o         pattern currently displayed
//   frame_cnt_o    completed-frame counter (wraps)

module pattern_gen #(
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int X_POS_W      = 10,
  parameter int Y_POS_W      = 10,
  parameter int COLOR_W      = 8,
  parameter int FRAME_W      = 8,
  parameter int CHECKER_LOG2 = 5,
  parameter int BOX_SIZE     = 32,
  parameter int BOX_STEP     = 4
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [2:0]         mode_i,
  input  logic               mode_valid_i,
  input  logic [X_POS_W-1:0] x_i,
  input  logic [Y_POS_W-1:0] y_i,
  output logic [COLOR_W-1:0] red_o,
  output logic [COLOR_W-1:0] green_o,
  output logic [COLOR_W-1:0] blue_o,
  output logic [2:0]         mode_o,
  output logic [FRAME_W-1:0] frame_cnt_o
);

  typedef enum logic [2:0] {
    MODE_BLACK   = 3'd0,
    MODE_BARS    = 3'd1,
    MODE_CHECKER = 3'd2,
    MODE_RAMP    = 3'd3,
    MODE_BOX     = 3'd4,
    MODE_RSVD5   = 3'd5,
    MODE_RSVD6   = 3'd6,
    MODE_RSVD7   = 3'd7
  } mode_e;

  // Forward = right on x, down on y.
  typedef enum logic {
    DIR_FWD = 1'b0,
    DIR_REV = 1'b1
  } dir_e;

  // Position arithmetic is one bit wider than the position ports so the box
  // edge sums can never wrap.
  localparam int XW = X_POS_W + 1;
  localparam int YW = Y_POS_W + 1;

  localparam logic [XW-1:0] H_ACT  = XW'(H_ACTIVE);
  localparam logic [XW-1:0] X_LIM  = XW'(H_ACTIVE - BOX_SIZE);
  localparam logic [XW-1:0] X_STEP = XW'(BOX_STEP);
  localparam logic [XW-1:0] X_SIZE = XW'(BOX_SIZE);
  localparam logic [XW-1:0] BAR_W  = XW'(H_ACTIVE / 8);

  localparam logic [YW-1:0] V_ACT  = YW'(V_ACTIVE);
  localparam logic [YW-1:0] Y_LIM  = YW'(V_ACTIVE - BOX_SIZE);
  localparam logic [YW-1:0] Y_STEP = YW'(BOX_STEP);
  localparam logic [YW-1:0] Y_SIZE = YW'(BOX_SIZE);

  localparam logic [COLOR_W-1:0] C_FULL = '1;
  localparam logic [COLOR_W-1:0] C_ZERO = '0;
  localparam logic [COLOR_W-1:0] C_GREY = COLOR_W'(1) << (COLOR_W - 1);

  // State
  logic               origin_q;
  mode_e              pending_q, mode_q;
  logic [FRAME_W-1:0] frame_cnt_q;
  logic [X_POS_W-1:0] box_x_q;
  logic [Y_POS_W-1:0] box_y_q;
  dir_e               dir_x_q, dir_y_q;
  logic [COLOR_W-1:0] red_q, green_q, blue_q;

  // Combinational
  logic               origin, frame_start;
  mode_e              mode_d;
  logic [FRAME_W-1:0] frame_cnt_d;
  logic [XW-1:0]      box_x_nx, box_x_d, x_ext;
  logic [YW-1:0]      box_y_nx, box_y_d, y_ext;
  dir_e               dir_x_nx, dir_x_d, dir_y_nx, dir_y_d;
  logic               active, in_box;
  logic [2:0]         bar_idx;
  logic [XW-1:0]      bar_edge;
  logic [COLOR_W-1:0] red_d, green_d, blue_d;

  assign x_ext = {1'b0, x_i};
  assign y_ext = {1'b0, y_i};

  // A frame starts on the first cycle at (0,0); holding the origin does not
  // retrigger it.
  assign origin      = (x_i == '0) && (y_i == '0);
  assign frame_start = origin && !origin_q;

  // Box motion, x axis: bounce off the right/left edges without overshoot.
  // NOTE: every variable assigned in an always_comb gets a default first, so
  // no path can leave it unassigned and infer a latch.
  always_comb begin
    box_x_nx = {1'b0, box_x_q};
    dir_x_nx = dir_x_q;
    if (dir_x_q == DIR_FWD) begin
      if ({1'b0, box_x_q} + X_STEP > X_LIM) begin
        box_x_nx = X_LIM;
        dir_x_nx = DIR_REV;
      end else begin
        box_x_nx = {1'b0, box_x_q} + X_STEP;
      end
    end else begin
      if ({1'b0, box_x_q} < X_STEP) begin
        box_x_nx = '0;
        dir_x_nx = DIR_FWD;
      end else begin
        box_x_nx = {1'b0, box_x_q} - X_STEP;
      end
    end
  end

  // Box motion, y axis: same rule against the active height.
  always_comb begin
    box_y_nx = {1'b0, box_y_q};
    dir_y_nx = dir_y_q;
    if (dir_y_q == DIR_FWD) begin
      if ({1'b0, box_y_q} + Y_STEP > Y_LIM) begin
        box_y_nx = Y_LIM;
        dir_y_nx = DIR_REV;
      end else begin
        box_y_nx = {1'b0, box_y_q} + Y_STEP;
      end
    end else begin
      if ({1'b0, box_y_q} < Y_STEP) begin
        box_y_nx = '0;
        dir_y_nx = DIR_FWD;
      end else begin
        box_y_nx = {1'b0, box_y_q} - Y_STEP;
      end
    end
  end

  // Values in effect for this pixel. In a frame-start cycle the pixel is drawn
  // with the freshly applied mode, count and box position, so the whole frame
  // is consistent. A mode write in that same cycle bypasses the pending reg.
  always_comb begin
    mode_d      = mode_q;
    frame_cnt_d = frame_cnt_q;
    box_x_d     = {1'b0, box_x_q};
    box_y_d     = {1'b0, box_y_q};
    dir_x_d     = dir_x_q;
    dir_y_d     = dir_y_q;
    if (frame_start) begin
      mode_d      = mode_valid_i ? mode_e'(mode_i) : pending_q;
      frame_cnt_d = frame_cnt_q + 1'b1;
      box_x_d     = box_x_nx;
      box_y_d     = box_y_nx;
      dir_x_d     = dir_x_nx;
      dir_y_d     = dir_y_nx;
    end
  end

  // Colour-bar index: count bar boundaries at or left of x. Avoids a divider
  // since the bar width need not be a power of two.
  always_comb begin
    bar_idx  = 3'd0;
    bar_edge = BAR_W;
    for (int k = 1; k < 8; k++) begin
      if (x_ext >= bar_edge) bar_idx = bar_idx + 3'd1;
      bar_edge = bar_edge + BAR_W;
    end
  end

  assign active = (x_ext < H_ACT) && (y_ext < V_ACT);
  assign in_box = (x_ext >= box_x_d) && (x_ext < box_x_d + X_SIZE) &&
                  (y_ext >= box_y_d) && (y_ext < box_y_d + Y_SIZE);

  // Pixel colour for the current position.
  always_comb begin
    red_d   = C_ZERO;
    green_d = C_ZERO;
    blue_d  = C_ZERO;
    case (mode_d)
      MODE_BLACK: ;
      MODE_BARS: begin
        // Bars run white, yellow, cyan, green, magenta, red, blue, black:
        // each channel is on for the bar indices whose selecting bit is 0.
        red_d   = bar_idx[1] ? C_ZERO : C_FULL;
        green_d = bar_idx[2] ? C_ZERO : C_FULL;
        blue_d  = bar_idx[0] ? C_ZERO : C_FULL;
      end
      MODE_CHECKER: begin
        if (x_i[CHECKER_LOG2] ^ y_i[CHECKER_LOG2]) begin
          red_d   = C_FULL;
          green_d = C_FULL;
          blue_d  = C_FULL;
        end
      end
      MODE_RAMP: begin
        red_d   = COLOR_W'(x_i);
        green_d = COLOR_W'(y_i);
        blue_d  = COLOR_W'(frame_cnt_d);
      end
      MODE_BOX: begin
        red_d   = in_box ? C_FULL : C_ZERO;
        green_d = in_box ? C_FULL : C_ZERO;
        blue_d  = C_FULL;
      end
      default: begin
        red_d   = C_GREY;
        green_d = C_GREY;
        blue_d  = C_GREY;
      end
    endcase
    if (!active) begin
      red_d   = C_ZERO;
      green_d = C_ZERO;
      blue_d  = C_ZERO;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      origin_q    <= 1'b0;
      pending_q   <= MODE_BLACK;
      mode_q      <= MODE_BLACK;
      frame_cnt_q <= '0;
      box_x_q     <= '0;
      box_y_q     <= '0;
      dir_x_q     <= DIR_FWD;
      dir_y_q     <= DIR_FWD;
      red_q       <= '0;
      green_q     <= '0;
      blue_q      <= '0;
    end else begin
      origin_q <= origin;
      if (mode_valid_i) pending_q <= mode_e'(mode_i);
      mode_q      <= mode_d;
      frame_cnt_q <= frame_cnt_d;
      box_x_q     <= box_x_d[X_POS_W-1:0];
      box_y_q     <= box_y_d[Y_POS_W-1:0];
      dir_x_q     <= dir_x_d;
      dir_y_q     <= dir_y_d;
      red_q       <= red_d;
      green_q     <= green_d;
      blue_q      <= blue_d;
    end
  end

  assign red_o       = red_q;
  assign green_o     = green_q;
  assign blue_o      = blue_q;
  assign mode_o      = mode_q;
  assign frame_cnt_o = frame_cnt_q;

endmodule

// File: tb/tb_pattern_gen.sv
// tb_pattern_gen -- scoreboard bench for pattern_gen (default parameters).
//
// A driver applies one pixel per clock and, after each active edge, steps a
// behavioural model of the generator and queues the expected outputs. A
// separate monitor pops one entry per falling edge and compares RGB, mode_o
// and frame_cnt_o. Directed spot checks with fixed expected values are layered
// on top for the documented corner cases.

module tb_pattern_gen;

  localparam int H = 640;
  localparam int V = 480;
  localparam int BOX = 32;
  localparam int STEP = 4;

  logic       clk = 1'b0;
  logic       rst_n_i = 1'b0;
  logic [2:0] mode_i = '0;
  logic       mode_valid_i = 1'b0;
  logic [9:0] x_i = '0;
  logic [9:0] y_i = '0;
  logic [7:0] red_o, green_o, blue_o;
  logic [2:0] mode_o;
  logic [7:0] frame_cnt_o;

  pattern_gen dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n_i),
    .mode_i       (mode_i),
    .mode_valid_i (mode_valid_i),
    .x_i          (x_i),
    .y_i          (y_i),
    .red_o        (red_o),
    .green_o      (green_o),
    .blue_o       (blue_o),
    .mode_o       (mode_o),
    .frame_cnt_o  (frame_cnt_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [23:0] rgb;
    int          mode;
    int          cnt;
  } exp_t;

  exp_t sb_q[$];

  // ---------------- reference model ----------------
  int m_mode, m_pend, m_cnt, m_bx, m_by, m_dx, m_dy;
  bit m_prev;

  task automatic model_reset();
    m_mode = 0; m_pend = 0; m_cnt = 0;
    m_bx = 0; m_by = 0; m_dx = 1; m_dy = 1;
    m_prev = 1'b0;
  endtask

  task automatic bounce(inout int pos, inout int dir, input int lim);
    if (dir > 0) begin
      if (pos + STEP > lim) begin pos = lim; dir = -1; end
      else pos = pos + STEP;
    end else begin
      if (pos < STEP) begin pos = 0; dir = 1; end
      else pos = pos - STEP;
    end
  endtask

  function automatic logic [23:0] bar_colour(int idx);
    case (idx)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic logic [23:0] render(int x, int y);
    if (x >= H || y >= V) return 24'h000000;
    case (m_mode)
      0: return 24'h000000;
      1: return bar_colour(x / (H / 8));
      2: return ((((x >> 5) ^ (y >> 5)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
      3: return 24'((x % 256) * 65536 + (y % 256) * 256 + (m_cnt % 256));
      4: return (x >= m_bx && x < m_bx + BOX && y >= m_by && y < m_by + BOX)
                ? 24'hFFFFFF : 24'h0000FF;
      default: return 24'h808080;
    endcase
  endfunction

  task automatic model_step(input int x, input int y, input bit mv, input int m);
    bit   origin;
    exp_t e;
    origin = (x == 0 && y == 0);
    if (mv) m_pend = m;
    if (origin && !m_prev) begin
      m_mode = m_pend;
      m_cnt  = (m_cnt + 1) % 256;
      bounce(m_bx, m_dx, H - BOX);
      bounce(m_by, m_dy, V - BOX);
    end
    m_prev = origin;
    e.rgb  = render(x, y);
    e.mode = m_mode;
    e.cnt  = m_cnt;
    sb_q.push_back(e);
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Monitor: one expected entry per clock, compared on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_cmp++;
        if ({red_o, green_o, blue_o} !== e.rgb || 32'(mode_o) !== 32'(e.mode) ||
            32'(frame_cnt_o) !== 32'(e.cnt)) begin
          n_bad++;
          $display("FAIL scoreboard: got rgb=%06h mode=%0d cnt=%0d, expected rgb=%06h mode=%0d cnt=%0d (t=%0t)",
                   {red_o, green_o, blue_o}, mode_o, frame_cnt_o, e.rgb, e.mode, e.cnt, $time);
        end
      end
    end
  end

  // Directed check armed by pix_chk, evaluated on the next falling edge.
  bit    chk_en = 1'b0;
  string chk_name;
  int    chk_rgb, chk_mode, chk_cnt;

  task automatic run_pending_check();
    if (chk_en) begin
      chk_en = 1'b0;
      if (chk_rgb  >= 0) check({chk_name, " rgb"},  32'({red_o, green_o, blue_o}), 32'(chk_rgb));
      if (chk_mode >= 0) check({chk_name, " mode"}, 32'(mode_o), 32'(chk_mode));
      if (chk_cnt  >= 0) check({chk_name, " cnt"},  32'(frame_cnt_o), 32'(chk_cnt));
    end
  endtask

  task automatic pix(input int x, input int y, input bit mv = 1'b0, input int m = 0);
    @(negedge clk);
    run_pending_check();
    x_i = 10'(x);
    y_i = 10'(y);
    mode_valid_i = mv;
    mode_i = 3'(m);
    @(posedge clk);
    model_step(x, y, mv, m);
  endtask

  task automatic pix_chk(input int x, input int y, input bit mv, input int m,
                         input string name, input int want_rgb, input int want_mode,
                         input int want_cnt);
    pix(x, y, mv, m);
    chk_en   = 1'b1;
    chk_name = name;
    chk_rgb  = want_rgb;
    chk_mode = want_mode;
    chk_cnt  = want_cnt;
  endtask

  // Let the last queued entry and any armed check resolve.
  task automatic flush();
    @(negedge clk);
    run_pending_check();
    #1;
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int ys[6] = '{0, 10, 100, 479, 480, 524};
    int xs[7] = '{0, 1, 80, 100, 639, 640, 799};
    int c0, n, r;

    model_reset();
    #3;
    check("reset rgb",  32'({red_o, green_o, blue_o}), 32'h0);
    check("reset mode", 32'(mode_o), 32'h0);
    check("reset cnt",  32'(frame_cnt_o), 32'h0);
    @(posedge clk);
    #2 rst_n_i = 1'b1;

    // 1: mode write mid-frame takes effect only at the next frame start.
    foreach (ys[i]) foreach (xs[j]) begin
      if (!(xs[j] == 0 && ys[i] == 0)) begin
        if (xs[j] == 100 && ys[i] == 10) pix(xs[j], ys[i], 1'b1, 1);
        else pix(xs[j], ys[i], 1'b0, 1);
      end
    end
    pix_chk(0, 0, 1'b0, 0, "t1 frame start", 32'hFFFFFF, 1, 1);
    pix_chk(80, 0, 1'b0, 0, "t1 bar yellow", 32'hFFFF00, 1, 1);
    pix_chk(639, 0, 1'b0, 0, "t1 bar black", 32'h000000, 1, 1);
    pix(400, 200);

    // 2: checkerboard and blanking.
    pix(5, 5, 1'b1, 2);
    pix(0, 0);
    pix_chk(31, 0, 1'b0, 0, "t2 (31,0)", 32'h000000, 2, -1);
    pix_chk(32, 0, 1'b0, 0, "t2 (32,0)", 32'hFFFFFF, 2, -1);
    pix_chk(32, 32, 1'b0, 0, "t2 (32,32)", 32'h000000, 2, -1);
    pix_chk(700, 0, 1'b0, 0, "t2 (700,0)", 32'h000000, 2, -1);

    // 3: ramp and frame-counter wrap.
    pix(5, 5, 1'b1, 3);
    pix(0, 0);
    pix_chk(300, 260, 1'b0, 0, "t3 ramp", 32'h2C0400 + m_cnt, 3, -1);
    c0 = m_cnt;
    repeat (256) begin
      pix(0, 0);
      pix($urandom_range(1, 799), $urandom_range(0, 524));
    end
    flush();
    check("t3 cnt wrap", 32'(frame_cnt_o), 32'(c0));

    // 4: bouncing box reaches the right edge and turns back.
    pix(5, 5, 1'b1, 4);
    n = 0;
    while (!(m_bx == H - BOX - STEP && m_dx < 0) && n < 400) begin
      pix(0, 0);
      pix($urandom_range(1, 799), $urandom_range(1, 524));
      n++;
    end
    pix_chk(607, m_by, 1'b0, 0, "t4 box inside", 32'hFFFFFF, 4, -1);
    pix_chk(603, m_by, 1'b0, 0, "t4 box outside", 32'h0000FF, 4, -1);

    // 5: bypass in the frame-start cycle; last write in a frame wins.
    pix(9, 9, 1'b1, 1);
    pix_chk(0, 0, 1'b1, 4, "t5 bypass", -1, 4, -1);
    pix(10, 10, 1'b1, 2);
    pix(20, 20, 1'b1, 5);
    pix(0, 0);
    pix_chk(30, 30, 1'b0, 0, "t5 last write", 32'h808080, 5, -1);

    // Randomised traffic: scattered pixels, frequent frame starts, mode writes.
    repeat (2000) begin
      r = $urandom_range(0, 99);
      if (r < 5) pix(0, 0, ($urandom_range(0, 15) == 0), $urandom_range(0, 7));
      else pix($urandom_range(0, 799), $urandom_range(0, 524),
               ($urandom_range(0, 15) == 0), $urandom_range(0, 7));
    end

    // 6: asynchronous reset mid-frame while a box pixel is lit.
    pix(1, 1, 1'b1, 4);
    pix(0, 0);
    pix(m_bx + 1, m_by + 1);
    flush();
    #2 rst_n_i = 1'b0;
    x_i = '0;
    y_i = '0;
    mode_valid_i = 1'b0;
    model_reset();
    sb_q.delete();
    #1;
    check("t6 async rgb",  32'({red_o, green_o, blue_o}), 32'h0);
    check("t6 async mode", 32'(mode_o), 32'h0);
    check("t6 async cnt",  32'(frame_cnt_o), 32'h0);
    repeat (2) @(posedge clk);
    @(posedge clk);
    #2 rst_n_i = 1'b1;
    repeat (9) pix(0, 0);
    pix_chk(0, 0, 1'b0, 0, "t6 held origin", 32'h000000, 0, 1);
    pix(3, 3, 1'b1, 4);
    pix(0, 0);
    pix_chk(8, 8, 1'b0, 0, "t6 box restart in", 32'hFFFFFF, 4, 2);
    pix_chk(7, 8, 1'b0, 0, "t6 box restart out", 32'h0000FF, 4, 2);
    flush();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
